biriscv_fetch_queue: RTL
========================

Name: biriscv_fetch_queue

Overview:
- Instruction queue between the 64-bit fetch unit and the dual-issue decoders.
- Buffers fetch packets (PC, two 32-bit instructions, fault flag) and presents up to two in-order instructions per cycle as valid/opcode/fault.
- Absorbs decode back-pressure and partial consumption: slot 0 issued, slot 1 stalled.
- Flushed on branch redirect.

Parameters:
- DEPTH, 2, number of packet entries (power of two, >= 2).
- PTR_W, 1, log2(DEPTH).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  discard all queued packets (branch redirect).
- fetch_valid_i  input  1  incoming packet valid.
- fetch_pc_i  input  32  packet PC; bit 2 set means only the upper instruction is valid.
- fetch_instr_i  input  64  [31:0] instruction at PC&~7, [63:32] instruction at (PC&~7)+4.
- fetch_fault_i  input  1  fetch fault for the packet.
- fetch_accept_o  output  1  queue can take a packet this cycle.
- dec0_valid_o  output  1  slot 0 instruction valid.
- dec0_opcode_o  output  32  slot 0 instruction.
- dec0_pc_o  output  32  slot 0 PC.
- dec0_fault_o  output  1  slot 0 fetch fault.
- dec0_accept_i  input  1  decoder 0 consumes slot 0.
- dec1_valid_o  output  1  slot 1 instruction valid.
- dec1_opcode_o  output  32  slot 1 instruction.
- dec1_pc_o  output  32  slot 1 PC.
- dec1_fault_o  output  1  always 0; faults issue on slot 0 only.
- dec1_accept_i  input  1  decoder 1 consumes slot 1.

Behaviour:
- Storage per entry: pc[31:3], instr[63:0], fault, vld[1:0]. Also rd_ptr, wr_ptr, count[PTR_W:0].
- Reset: all pointers, count and vld bits = 0.
  - Outputs: fetch_accept_o=1, all dec*_valid_o=0, all data outputs 0.
- Push: fetch_valid_i && fetch_accept_o && !flush_i.
  - Writes entry[wr_ptr] with vld = {1, ~fetch_pc_i[2]}.
  - Fault packet: vld = 2'b01 with the fault flag set.
  - wr_ptr wraps modulo DEPTH.
- fetch_accept_o = (count != DEPTH). Registered count; no same-cycle pop credit.
- Head presentation, combinational from entry[rd_ptr], count != 0:
  - vld=11: slot0 = lower instruction (pc = base), slot1 = upper instruction (base+4).
  - vld=10: slot0 = upper instruction (base+4), slot1 invalid.
  - vld=01: slot0 = lower instruction, slot1 invalid.
  - dec0_fault_o = entry fault when dec0_valid_o.
- Consumption:
  - dec1_accept_i is ignored unless dec0_accept_i is also set (in-order).
  - Both consumed, or the single remaining one consumed: pop, rd_ptr++, count--.
  - vld=11 and only slot0 consumed: vld becomes 10, no pop; the upper instruction moves to slot 0 next cycle.
- Push and pop in the same cycle: count unchanged, pointers both advance.
  - Full queue: no push even if a pop occurs.
- flush_i has priority over push and pop.
  - Next cycle: count=0, pointers=0, all vld=0, dec*_valid_o=0.
  - Accepts asserted in the flush cycle have no effect on state.
- Reset mid-operation: asynchronous clear to reset state; no partial packet survives.
- Latency: packet pushed in cycle N is visible on dec0 in cycle N+1 (when the queue was empty, feature off).

Optional Feature:
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and a push occurs, the incoming packet drives the dec outputs in the same cycle, combinationally.
  - Fully consumed that cycle: not written.
  - Partially consumed: written with the remaining vld bits.
  - Not consumed: written normally.
  - flush_i suppresses the bypass.
- Undefined: no bypass; minimum latency is 1 cycle.

Test Plan:
- Reset release, no fetch -> fetch_accept_o=1, dec0_valid_o=dec1_valid_o=0.
- Push pc=0x80000000, instr=0x00208133_00100093, both accepts held high -> cycle +1:
  - dec0: opcode 0x00100093, pc 0x80000000.
  - dec1: opcode 0x00208133, pc 0x80000004.
  - Cycle +2: queue empty.
- Same packet, dec0_accept_i=1, dec1_accept_i=0 -> next cycle dec0 shows 0x00208133 @0x80000004, dec1_valid_o=0; accepting it empties the queue.
- Push pc=0x80000104 (bit2=1) -> only dec0 valid, opcode = instr[63:32], pc 0x80000104.
  - Push with fetch_fault_i=1 -> dec0_fault_o=1, dec1_valid_o=0.
- Accepts held low, push DEPTH+1 packets -> fetch_accept_o=0 after DEPTH pushes, the extra packet is not stored.
  - Assert flush_i with fetch_valid_i=1 -> next cycle empty, fetch_accept_o=1.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push and accept both in the same cycle -> dec0/dec1 valid in the same cycle, count stays 0.

Source files
------------

// File: rtl/biriscv_fetch_queue.sv
// Fetch packet queue between the 64-bit fetch unit and the dual-issue decoders.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module biriscv_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [63:0] fetch_instr_i,
    input  logic        fetch_fault_i,
    output logic        fetch_accept_o,
    output logic        dec0_valid_o,
    output logic [31:0] dec0_opcode_o,
    output logic [31:0] dec0_pc_o,
    output logic        dec0_fault_o,
    input  logic        dec0_accept_i,
    output logic        dec1_valid_o,
    output logic [31:0] dec1_opcode_o,
    output logic [31:0] dec1_pc_o,
    output logic        dec1_fault_o,
    input  logic        dec1_accept_i
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:3]      pc_q    [DEPTH];
    logic [63:0]      instr_q [DEPTH];
    logic             fault_q [DEPTH];
    logic [1:0]       vld_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;

    logic        push;
    logic        bypass;
    logic [1:0]  in_vld;
    logic        head_valid;
    logic [1:0]  head_vld;
    logic [31:3] head_pc;
    logic [63:0] head_instr;
    logic        head_fault;
    logic        head_both;
    logic        take0;
    logic        take1;
    logic        pop;
    logic        partial;
    logic        mem_pop;
    logic        mem_partial;
    logic        do_write;
    logic [1:0]  wr_vld;
    logic        unused_pc_lsb;

    assign unused_pc_lsb  = ^fetch_pc_i[1:0];

    assign fetch_accept_o = (count_q != FULL_CNT);
    assign push           = fetch_valid_i && fetch_accept_o && !flush_i;
    // vld[1] = upper word present, vld[0] = lower word present; faults carry only slot 0
    assign in_vld         = fetch_fault_i ? 2'b01 : {1'b1, ~fetch_pc_i[2]};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = push && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        head_valid = (count_q != '0);
        head_vld   = vld_q[rd_ptr_q];
        head_pc    = pc_q[rd_ptr_q];
        head_instr = instr_q[rd_ptr_q];
        head_fault = fault_q[rd_ptr_q];
        if (bypass) begin
            head_valid = 1'b1;
            head_vld   = in_vld;
            head_pc    = fetch_pc_i[31:3];
            head_instr = fetch_instr_i;
            head_fault = fetch_fault_i;
        end
    end

    assign head_both     = (head_vld == 2'b11);

    assign dec0_valid_o  = head_valid;
    assign dec0_opcode_o = !head_valid ? 32'd0 :
                           (head_vld == 2'b10) ? head_instr[63:32] : head_instr[31:0];
    assign dec0_pc_o     = !head_valid ? 32'd0 :
                           {head_pc, (head_vld == 2'b10) ? 3'b100 : 3'b000};
    assign dec0_fault_o  = head_valid && head_fault;

    assign dec1_valid_o  = head_valid && head_both;
    assign dec1_opcode_o = dec1_valid_o ? head_instr[63:32] : 32'd0;
    assign dec1_pc_o     = dec1_valid_o ? {head_pc, 3'b100} : 32'd0;
    assign dec1_fault_o  = 1'b0;

    // Slot 1 only counts when slot 0 goes in the same cycle, keeping issue in order
    assign take0   = dec0_valid_o && dec0_accept_i && !flush_i;
    assign take1   = take0 && dec1_valid_o && dec1_accept_i;
    assign pop     = take0 && (!head_both || take1);
    assign partial = take0 && head_both && !take1;

    // A bypassed packet never occupies storage unless something is left over
    assign mem_pop     = pop && !bypass;
    assign mem_partial = partial && !bypass;
    assign do_write    = push && !(bypass && pop);
    assign wr_vld      = (bypass && partial) ? 2'b10 : in_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '{default: 2'b00};
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '{default: 2'b00};
        end else begin
            if (mem_pop) begin
                vld_q[rd_ptr_q] <= 2'b00;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end else if (mem_partial) begin
                vld_q[rd_ptr_q] <= 2'b10;
            end
            if (do_write) begin
                vld_q[wr_ptr_q] <= wr_vld;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            case ({do_write, mem_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage is qualified by vld_q, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            pc_q[wr_ptr_q]    <= fetch_pc_i[31:3];
            instr_q[wr_ptr_q] <= fetch_instr_i;
            fault_q[wr_ptr_q] <= fetch_fault_i;
        end
    end

endmodule
